cpu_step_ctrl: RTL and testbench



---
 rtl/cpu_step_ctrl_pkg.sv | 13 +
 rtl/cpu_step_ctrl_key_debounce.sv | 56 +++++
 rtl/cpu_step_ctrl.sv | 112 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the manual/free-run CPU clock-enable sequencer.
// The board top imports the mode encodings to decode `mode` for display.
package cpu_step_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BREAK = 2'd2;

    function automatic logic is_halt_state(input logic [1:0] st);
        return st == ST_BREAK;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_key_debounce.sv
// Step-key synchronizer and debouncer; emits a one-cycle press pulse on an
// accepted 1->0 transition of the debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_step,
    output logic key_db,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = key_step;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = '0;
        // Any agreeing sample restarts the stability window.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_db = db_q;
    assign press  = db_prev_q & ~db_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the single-cycle core: manual steps from a
// debounced key, or periodic steps in run mode halting at a PC breakpoint.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int RUN_DIV         = 4,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_step,
    input  logic            run_en,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            cpu_ce,
    output logic            halted,
    output logic [31:0]     step_count,
    output logic [1:0]      mode
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             press;
    logic             key_db;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [31:0]      step_count_q, step_count_d;
    logic             bp_hit;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_step (key_step),
        .key_db   (key_db),
        .press    (press)
    );

    assign bp_hit = bp_en && (pc == bp_addr);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_ce_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_ce_d = press;
                if (run_en) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end
            end
            ST_RUN: begin
                // Leaving run mode wins over a breakpoint decision this cycle.
                if (!run_en) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                    end else begin
                        cpu_ce_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (!run_en) begin
                    state_d  = ST_IDLE;
                    cpu_ce_d = press;
                end else if (press) begin
                    cpu_ce_d = 1'b1;
                    state_d  = ST_RUN;
                    div_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    assign step_count_d = step_count_q + {31'd0, cpu_ce_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            cpu_ce_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_ce_q     <= cpu_ce_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign halted     = is_halt_state(state_q);
    assign step_count = step_count_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=4.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_step = 1'b1;
    logic        run_en = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] pc = '0;
    logic        cpu_ce;
    logic        halted;
    logic [31:0] step_count;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = 0;
    int first_pulse = -1;
    logic ce_prev = 1'b0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(4),
        .PC_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_step   (key_step),
        .run_en     (run_en),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .step_count (step_count),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge. The processor
    // model advances pc by 4 on each enable.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_ce) begin
            chk("pulse_gap", {31'd0, ce_prev}, 32'd0);
            pulses++;
            last_pulse_cyc = cyc;
            pc = pc + 32'd4;
        end
        ce_prev = cpu_ce;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        pc = '0;
        pulses = 0;
    endtask

    int t_start;
    int gap_ok;
    int found;

    initial begin
        // Reset values
        do_reset();
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", step_count, 32'd0);

        // 1. Manual step: pulse 7 edges after first low sample
        key_step = 1'b0;
        t_start = cyc;
        first_pulse = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ce && first_pulse < 0) first_pulse = cyc - t_start;
        end
        chk("man_pulses", pulses, 32'd1);
        chk("man_latency", first_pulse, 32'd7);
        chk("man_count", step_count, 32'd1);
        key_step = 1'b1;
        ticks(20);
        chk("man_release", pulses, 32'd1);
        chk("man_count2", step_count, 32'd1);

        // 2. Bounce rejection
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if ((i % 2) == 0) key_step = ~key_step;
            tick();
        end
        key_step = 1'b1;
        ticks(10);
        chk("bounce_pulses", pulses, 32'd0);
        chk("bounce_count", step_count, 32'd0);

        // 3. Free run: 10 pulses 4 cycles apart
        do_reset();
        run_en = 1'b1;
        gap_ok = 1;
        for (int i = 0; i < 41; i++) begin
            int prev;
            prev = last_pulse_cyc;
            tick();
            if (cpu_ce && pulses > 1 && (cyc - prev) != 4) gap_ok = 0;
        end
        chk("run_pulses", pulses, 32'd10);
        chk("run_spacing", gap_ok, 32'd1);
        chk("run_mode", {30'd0, mode}, 32'd1);
        run_en = 1'b0;
        tick();
        chk("stop_mode", {30'd0, mode}, 32'd0);
        ticks(10);
        chk("stop_pulses", pulses, 32'd10);
        chk("stop_count", step_count, 32'd10);

        // 4. Breakpoint at 0xC
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        run_en = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (mode == 2'd2) found = 1;
        end
        chk("bp_reached", found, 32'd1);
        chk("bp_pulses", pulses, 32'd3);
        chk("bp_pc", pc, 32'h0000_000C);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        ticks(12);
        chk("bp_hold_pulses", pulses, 32'd3);
        chk("bp_hold_mode", {30'd0, mode}, 32'd2);
        bp_addr = 32'h0000_0040;
        tick();
        chk("bp_addr_change", {30'd0, mode}, 32'd2);
        bp_addr = 32'h0000_000C;
        key_step = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (cpu_ce) found = 1;
        end
        chk("bp_step", found, 32'd1);
        chk("bp_step_pc", pc, 32'h0000_0010);
        chk("bp_step_halted", {31'd0, halted}, 32'd0);
        chk("bp_step_mode", {30'd0, mode}, 32'd1);
        key_step = 1'b1;
        ticks(4);
        chk("bp_resume", pulses, 32'd5);
        chk("bp_resume_pc", pc, 32'h0000_0014);

        // 5. Reset mid-run at step_count 5
        do_reset();
        bp_en = 1'b0;
        run_en = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (step_count == 32'd5) found = 1;
        end
        chk("mid_reached", found, 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_count", step_count, 32'd0);
        chk("mid_mode", {30'd0, mode}, 32'd0);
        chk("mid_ce", {31'd0, cpu_ce}, 32'd0);
        rst = 1'b1;
        run_en = 1'b0;

        // 6. step_count wrap
        do_reset();
        @(negedge clk);
        force dut.step_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_count_q;
        tick();
        chk("wrap_preset", step_count, 32'hFFFF_FFFF);
        key_step = 1'b0;
        ticks(10);
        chk("wrap_pulses", pulses, 32'd1);
        chk("wrap_count", step_count, 32'd0);
        key_step = 1'b1;
        ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
